lfsr8_stream_checker: RTL



---
 rtl/lfsr8_pkg.sv | 6 +
 rtl/lfsr8_stream_checker_if.sv | 8 +
 rtl/lfsr8_step.sv | 9 +
 rtl/lfsr8_stream_checker.sv | 93 +++++++++
 4 files changed

// File: rtl/lfsr8_pkg.sv
// lfsr8_pkg: shared polynomial, lockup pattern and checker state encoding
package lfsr8_pkg;
   localparam logic [7:0] TAPS = 8'b1000_1110;
   localparam logic [7:0] LOCKUP = 8'hFF;
   typedef enum logic [1:0] {SEED, ACQUIRE, LOCKED} state_t;
endpackage

// File: rtl/lfsr8_stream_checker_if.sv
// lfsr8_stream_checker_if: stream input and checker status bundle
interface lfsr8_stream_checker_if #(parameter int CNT_WIDTH = 16);
   logic valid_i, data_i, clear_i;
   logic locked_o, err_o, lockup_o;
   logic [CNT_WIDTH-1:0] err_cnt_o, bit_cnt_o;
   modport master(output valid_i, data_i, clear_i, input locked_o, err_o, lockup_o, err_cnt_o, bit_cnt_o);
   modport slave(input valid_i, data_i, clear_i, output locked_o, err_o, lockup_o, err_cnt_o, bit_cnt_o);
endinterface

// File: rtl/lfsr8_step.sv
// lfsr8_step: XNOR feedback bit of the 8-bit LFSR from its history
module lfsr8_step
   import lfsr8_pkg::*;
(
   input  logic [7:0] hist,
   output logic       exp
);
   assign exp = ~^(hist & TAPS);
endmodule

// File: rtl/lfsr8_stream_checker.sv
// lfsr8_stream_checker: self-synchronising LFSR stream checker with lock and error counting
module lfsr8_stream_checker
   import lfsr8_pkg::*;
#(
   parameter int LOCK_CNT = 16,
   parameter int UNLOCK_CNT = 4,
   parameter int CNT_WIDTH = 16
) (
   input logic clk,
   input logic rst,
   lfsr8_stream_checker_if.slave s
);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int UW = $clog2(UNLOCK_CNT + 1);
   state_t state, state_n;
   logic [7:0] hist, hist_n;
   logic [2:0] seed, seed_n;
   logic [MW-1:0] match, match_n;
   logic [UW-1:0] miss, miss_n;
   logic [CNT_WIDTH-1:0] err_cnt_n, bit_cnt_n;
   logic exp, miss_bit, err_n, bit_inc, err_inc;
   lfsr8_step u_step (.hist(hist), .exp(exp));
   assign miss_bit = s.data_i != exp;
   assign bit_inc = s.valid_i && state == LOCKED;
   assign err_inc = bit_inc && miss_bit;
   assign bit_cnt_n = s.clear_i ? CNT_WIDTH'(bit_inc) : (bit_inc && ~&s.bit_cnt_o) ? s.bit_cnt_o + 1'b1 : s.bit_cnt_o;
   assign err_cnt_n = s.clear_i ? CNT_WIDTH'(err_inc) : (err_inc && ~&s.err_cnt_o) ? s.err_cnt_o + 1'b1 : s.err_cnt_o;
   always_comb begin
      state_n = state;
      hist_n = hist;
      seed_n = seed;
      match_n = match;
      miss_n = miss;
      err_n = 1'b0;
      if (s.valid_i) begin
         case (state)
            SEED: begin
               hist_n = {hist[6:0], s.data_i};
               seed_n = seed + 3'd1;
               if (seed == 3'd7) begin
                  state_n = ACQUIRE;
                  match_n = '0;
               end
            end
            ACQUIRE: begin
               hist_n = {hist[6:0], s.data_i};
               match_n = (miss_bit || hist_n == LOCKUP) ? '0 : match + 1'b1;
               if (match_n == MW'(LOCK_CNT)) begin
                  state_n = LOCKED;
                  miss_n = '0;
               end
            end
            LOCKED: begin
               // track the local sequence so one corrupted bit costs one error
               hist_n = {hist[6:0], exp};
               err_n = miss_bit;
               miss_n = miss_bit ? miss + 1'b1 : '0;
               if (miss_n == UW'(UNLOCK_CNT)) begin
                  state_n = SEED;
                  seed_n = '0;
                  match_n = '0;
               end
            end
            default: state_n = SEED;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SEED;
         hist <= '0;
         seed <= '0;
         match <= '0;
         miss <= '0;
         s.locked_o <= 1'b0;
         s.err_o <= 1'b0;
         s.lockup_o <= 1'b0;
         s.err_cnt_o <= '0;
         s.bit_cnt_o <= '0;
      end else begin
         state <= state_n;
         hist <= hist_n;
         seed <= seed_n;
         match <= match_n;
         miss <= miss_n;
         s.locked_o <= state_n == LOCKED;
         s.err_o <= err_n;
         s.lockup_o <= hist_n == LOCKUP && state_n != LOCKED;
         s.err_cnt_o <= err_cnt_n;
         s.bit_cnt_o <= bit_cnt_n;
      end
   end
endmodule
